mux_one_to_three: RTL and testbench
===================================

// Module: mux_one_to_three
// PURPOSE
//  - Registered 1-to-3 demultiplexer in the multiplier datapath.
//  - Routes one WIDTH-bit input word (entrada) to one of three output registers (a, b, c), selected by op.
//  - Downstream multiplier logic reads operands/partials from a, b, c.
//  - Also provides per-output load strobes and an illegal-select flag.
// PARAMETERS
//  - WIDTH  10  bit width of entrada and of each of a, b, c
// PORTS
//  - Interface: one clock; reset is synchronous and active-low.
//  - clock    in   1      rising-edge clock, sole clock domain
//  - reset    in   1      synchronous active-low reset (0 = reset)
//  - op       in   2      select: 00->a, 01->b, 10->c, 11->illegal
//  - entrada  in   WIDTH  data word to route
//  - a        out  WIDTH  output register A
//  - b        out  WIDTH  output register B
//  - c        out  WIDTH  output register C
//  - a_ld     out  1      1-cycle strobe: a loaded on the last edge
//  - b_ld     out  1      1-cycle strobe: b loaded on the last edge
//  - c_ld     out  1      1-cycle strobe: c loaded on the last edge
//  - op_err   out  1      1-cycle strobe: op==11 sampled on the last edge
// BEHAVIOUR
//  - All outputs are registers updated only on the rising clock edge; no combinational input-to-output path.
//  - Reset: at an edge with reset==0, a=b=c=0 and a_ld=b_ld=c_ld=op_err=0.
//    - Reset overrides op/entrada.
//    - Reset asserted mid-stream discards that cycle's input.
//  - Latency: entrada sampled at edge N is visible on the selected output after edge N (one cycle).
//  - op=00: a<=entrada, a_ld<=1.
//  - op=01: b<=entrada, b_ld<=1.
//  - op=10: c<=entrada, c_ld<=1.
//  - op=11: no data register changes; op_err<=1.
//  - Unselected data registers hold their value (default build).
//  - Strobes not asserted for the current edge return to 0; at most one of {a_ld, b_ld, c_ld, op_err} is high.
//  - Consecutive cycles with the same op reload the same register every edge; its strobe stays high.
//  - Data is passed unmodified: no arithmetic, truncation or extension. All WIDTH bits are copied, including all-ones.
//  - X/Z on op is not supported; the bench drives only 0/1.
// CONFIGURATION
//  - Macro MUX_ONE_TO_THREE_ZERO_UNSEL_EN.
//    - Defined: on every non-reset edge, each unselected data register is cleared to 0. For op=11, all of a, b and c are cleared to 0. Strobes are unchanged.
//    - Undefined (default): unselected registers hold, as described in BEHAVIOUR.
// TESTING
//  - Reset: reset=0 for 2 edges with op=00, entrada=2 -> a=b=c=0, all strobes 0.
//  - Routing: op=00/ent=2, op=01/ent=4, op=10/ent=6 on three edges -> a=2, b=4, c=6 after the third edge; a_ld, b_ld, c_ld high one cycle each, in order.
//  - Hold/overwrite: then op=00/ent=8, op=00/ent=10, op=01/ent=12 -> a=10, b=12, c=6.
//    - With MUX_ONE_TO_THREE_ZERO_UNSEL_EN: a=0, b=12, c=0.
//  - Illegal op: a=10, b=12, c=6; op=11, ent=1023 -> a/b/c unchanged, op_err=1 for exactly one cycle.
//  - Full width: op=10, ent=1023 -> c=1023; then op=10, ent=0 -> c=0; c_ld stays high both cycles.
//  - Reset mid-stream: op=01, ent=5 with reset=0 at that edge -> b=0 (not 5), b_ld=0; normal routing resumes on the next edge with reset=1.

Source files
------------

// File: rtl/mux_one_to_three.sv
`default_nettype none
// ============================================================================
// Module   : mux_one_to_three
// Summary  : Registered 1-to-3 demux that routes one word to a, b or c.
//            It also drives per-output load strobes and an illegal-select flag.
// Option   : MUX_ONE_TO_THREE_ZERO_UNSEL_EN clears the unselected data registers.
// Revision : 1.0 - initial release
// ============================================================================
module mux_one_to_three #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             a_ld,
  output logic             b_ld,
  output logic             c_ld,
  output logic             op_err
);

  localparam logic [1:0] C_OP_A   = 2'b00;
  localparam logic [1:0] C_OP_B   = 2'b01;
  localparam logic [1:0] C_OP_C   = 2'b10;
  localparam logic [1:0] C_OP_ERR = 2'b11;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic             r_a_ld;
  logic             r_b_ld;
  logic             r_c_ld;
  logic             r_op_err;

  // Strobes decode straight from op, so at most one of them is high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_a_ld   <= 1'b0;
      r_b_ld   <= 1'b0;
      r_c_ld   <= 1'b0;
      r_op_err <= 1'b0;
    end else begin
      r_a_ld   <= (op == C_OP_A);
      r_b_ld   <= (op == C_OP_B);
      r_c_ld   <= (op == C_OP_C);
      r_op_err <= (op == C_OP_ERR);
`ifdef MUX_ONE_TO_THREE_ZERO_UNSEL_EN
      r_a <= (op == C_OP_A) ? entrada : '0;
      r_b <= (op == C_OP_B) ? entrada : '0;
      r_c <= (op == C_OP_C) ? entrada : '0;
`else
      case (op)
        C_OP_A:  r_a <= entrada;
        C_OP_B:  r_b <= entrada;
        C_OP_C:  r_c <= entrada;
        default: ;
      endcase
`endif
    end
  end

  assign a      = r_a;
  assign b      = r_b;
  assign c      = r_c;
  assign a_ld   = r_a_ld;
  assign b_ld   = r_b_ld;
  assign c_ld   = r_c_ld;
  assign op_err = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_one_to_three.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_one_to_three
// Summary  : Directed self-checking bench for mux_one_to_three.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_one_to_three;

  localparam int WIDTH = 10;

  logic             clock;
  logic             reset;
  logic [1:0]       op;
  logic [WIDTH-1:0] entrada;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             a_ld;
  logic             b_ld;
  logic             c_ld;
  logic             op_err;

  int n_vec;
  int n_err;

  mux_one_to_three #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .op      (op),
    .entrada (entrada),
    .a       (a),
    .b       (b),
    .c       (c),
    .a_ld    (a_ld),
    .b_ld    (b_ld),
    .c_ld    (c_ld),
    .op_err  (op_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic rst_n, input logic [1:0] sel, input logic [WIDTH-1:0] ent);
    @(negedge clock);
    reset   = rst_n;
    op      = sel;
    entrada = ent;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks all three data registers and the four strobes in {a_ld,b_ld,c_ld,op_err} order.
  task automatic chk_all(input string tag, input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                         input logic [WIDTH-1:0] ec, input logic [3:0] estb);
    chk({tag, ".a"}, a, ea);
    chk({tag, ".b"}, b, eb);
    chk({tag, ".c"}, c, ec);
    chk({tag, ".strobes"}, {6'd0, a_ld, b_ld, c_ld, op_err}, {6'd0, estb});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b0;
    op      = 2'b00;
    entrada = '0;

    step(1'b0, 2'b00, 10'd2);
    chk_all("reset1", 10'd0, 10'd0, 10'd0, 4'b0000);
    step(1'b0, 2'b00, 10'd2);
    chk_all("reset2", 10'd0, 10'd0, 10'd0, 4'b0000);

`ifdef MUX_ONE_TO_THREE_ZERO_UNSEL_EN
    step(1'b1, 2'b00, 10'd2);
    chk_all("route_a", 10'd2, 10'd0, 10'd0, 4'b1000);
    step(1'b1, 2'b01, 10'd4);
    chk_all("route_b", 10'd0, 10'd4, 10'd0, 4'b0100);
    step(1'b1, 2'b10, 10'd6);
    chk_all("route_c", 10'd0, 10'd0, 10'd6, 4'b0010);
    step(1'b1, 2'b00, 10'd8);
    chk_all("ovr_a8", 10'd8, 10'd0, 10'd0, 4'b1000);
    step(1'b1, 2'b00, 10'd10);
    chk_all("ovr_a10", 10'd10, 10'd0, 10'd0, 4'b1000);
    step(1'b1, 2'b01, 10'd12);
    chk_all("ovr_b12", 10'd0, 10'd12, 10'd0, 4'b0100);
    step(1'b1, 2'b11, 10'd1023);
    chk_all("illegal", 10'd0, 10'd0, 10'd0, 4'b0001);
    step(1'b1, 2'b10, 10'd1023);
    chk_all("full_c", 10'd0, 10'd0, 10'd1023, 4'b0010);
    step(1'b1, 2'b10, 10'd0);
    chk_all("zero_c", 10'd0, 10'd0, 10'd0, 4'b0010);
`else
    step(1'b1, 2'b00, 10'd2);
    chk_all("route_a", 10'd2, 10'd0, 10'd0, 4'b1000);
    step(1'b1, 2'b01, 10'd4);
    chk_all("route_b", 10'd2, 10'd4, 10'd0, 4'b0100);
    step(1'b1, 2'b10, 10'd6);
    chk_all("route_c", 10'd2, 10'd4, 10'd6, 4'b0010);
    step(1'b1, 2'b00, 10'd8);
    chk_all("ovr_a8", 10'd8, 10'd4, 10'd6, 4'b1000);
    step(1'b1, 2'b00, 10'd10);
    chk_all("ovr_a10", 10'd10, 10'd4, 10'd6, 4'b1000);
    step(1'b1, 2'b01, 10'd12);
    chk_all("ovr_b12", 10'd10, 10'd12, 10'd6, 4'b0100);
    step(1'b1, 2'b11, 10'd1023);
    chk_all("illegal", 10'd10, 10'd12, 10'd6, 4'b0001);
    step(1'b1, 2'b10, 10'd1023);
    chk_all("full_c", 10'd10, 10'd12, 10'd1023, 4'b0010);
    step(1'b1, 2'b10, 10'd0);
    chk_all("zero_c", 10'd10, 10'd12, 10'd0, 4'b0010);
`endif

    // Reset asserted mid-stream must discard that cycle's write to b.
    step(1'b0, 2'b01, 10'd5);
    chk_all("mid_reset", 10'd0, 10'd0, 10'd0, 4'b0000);
    step(1'b1, 2'b01, 10'd5);
    chk_all("resume_b", 10'd0, 10'd5, 10'd0, 4'b0100);
    step(1'b1, 2'b00, 10'd1023);
`ifdef MUX_ONE_TO_THREE_ZERO_UNSEL_EN
    chk_all("full_a", 10'd1023, 10'd0, 10'd0, 4'b1000);
`else
    chk_all("full_a", 10'd1023, 10'd5, 10'd0, 4'b1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
